leb128_decoder: RTL
===================

Name: leb128_decoder

Overview:
- Streaming LEB128 immediate decoder for the WASM core; sits between the ROM byte window and the core's operand path.
- Consumes one byte per accepted beat and emits the decoded i32/i64 immediate used by i32.const, i64.const, branch depths and memarg fields.
- Runtime-selectable signed/unsigned mode and 32/64-bit target width.
- Reports malformed encodings as trap codes in the core's 4-bit trap format.

Parameters:
- MAX_WIDTH, 64: output width; legal values 32 or 64. When 32, width_sel is ignored and forced to 32-bit.
- LEN_W, 4: width of the consumed-byte count.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- abort  in  1  synchronous clear of any decode in progress
- in_valid  in  1  in_byte is valid this cycle
- in_ready  out  1  decoder accepts a byte this cycle
- in_byte  in  8  LEB128 byte, bit7 = continuation
- signed_mode  in  1  1 = SLEB128, 0 = ULEB128; sampled on first byte
- width_sel  in  1  1 = 64-bit target, 0 = 32-bit target; sampled on first byte
- out_valid  out  1  decoded value available
- out_ready  in  1  consumer takes the value
- out_value  out  MAX_WIDTH  decoded value, extended to MAX_WIDTH
- out_len  out  LEN_W  number of bytes consumed (1..10)
- trap  out  4  0 none, 1 too long, 2 overflow, 3 non-canonical

Behaviour:
- Reset (reset low, asynchronous): state ACCUM; accumulator, count, out_value, out_len and trap cleared to 0; out_valid=0; in_ready=1.
- States: ACCUM, DONE, ERROR.
- ACCUM:
  - in_ready=1.
  - On handshake: acc |= (in_byte[6:0] << 7*count), count++.
  - If count==0, latch signed_mode and width_sel for the whole value.
- Byte limit: N = 5 for 32-bit, 10 for 64-bit.
- Last-allowed byte (count==N-1), checks in this order:
  - bit7=1 -> ERROR, trap=1.
  - Unsigned 32: in_byte[6:4] must be 0. Unsigned 64: in_byte[6:1] must be 0.
  - Signed 32: in_byte[6:4] must equal in_byte[3]. Signed 64: in_byte[6:0] must be 0x00 or 0x7F.
  - Any check failing -> ERROR, trap=2.
- Terminating byte (bit7=0, no trap) -> DONE on the next edge:
  - out_valid=1 one cycle after the final byte is accepted.
  - out_len=count.
  - Sign extension: if signed and in_byte[6]=1 and 7*count < target width, fill bits above 7*count with 1.
  - 32-bit results are extended to MAX_WIDTH: sign-extended if signed, zero-extended if unsigned.
- DONE:
  - in_ready=0.
  - out_value and out_len stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid=0, accumulator cleared, back to ACCUM. The next byte can be accepted the following cycle.
- ERROR:
  - in_ready=0, out_valid=0, trap held (sticky).
  - Left only by abort or reset.
- abort: highest priority after reset. In any state, on the next edge: -> ACCUM, accumulator and count cleared, trap=0, out_valid=0. A byte presented in the same cycle is not consumed.
- The decoder does not accept a new byte in the cycle it presents out_valid; there is no input/output overlap.

Optional Feature:
- Macro LEB128_STRICT_EN.
- Defined: reject padded encodings. A multi-byte value whose final byte is 0x00 (unsigned, or signed with the previous byte's bit6=0), or 0x7F (signed with the previous byte's bit6=1), -> ERROR, trap=3.
- Not defined: padded encodings are accepted per the WASM spec; trap code 3 is never produced.

Test Plan:
- Unsigned 32, byte 0x2A -> out_valid one cycle after accept; out_value=42 (upper bits 0), out_len=1, trap=0.
- Signed 32, bytes 0xC0 0xBB 0x78 -> out_value=0xFFFF_FFFF_FFFE_1DC0 (-123456), out_len=3. Signed 32, 0x7F -> all ones, out_len=1.
- Unsigned 64, bytes 0xE5 0x8E 0x26 -> out_value=624485, out_len=3. Padded 0x80 0x00 -> 0 with len 2 when LEB128_STRICT_EN is undefined; trap=3 when it is defined.
- Signed 32, bytes 0x80 0x80 0x80 0x80 0x10 -> trap=2. Unsigned 32, five 0x80 bytes -> trap=1. Both: in_ready=0 until abort, then 0x01 decodes to 1.
- Backpressure: decode 0x2A with out_ready low for 3 cycles -> out_value=42 held, in_ready=0 throughout; out_ready high -> in_ready=1 the next cycle.
- Reset low asynchronously after 2 bytes of 0xE5 0x8E -> outputs cleared immediately; after release, 0x05 decodes to 5, out_len=1.

Source files
------------

// File: rtl/leb128_decoder.sv
// ---------------------------------------------------------------------------
// leb128_decoder
//   Streaming LEB128 immediate decoder for the WASM core. Accepts one byte per
//   handshake beat, accumulates 7 payload bits per byte and presents the
//   decoded i32/i64 immediate (extended to MAX_WIDTH) with its byte length.
//   Malformed encodings park the block in a sticky error state with a 4-bit
//   trap code (1 too long, 2 overflow, 3 non-canonical) until abort or reset.
//
//   Optional build macro: LEB128_STRICT_EN
//     defined   - padded (non-minimal) encodings are rejected with trap 3
//     undefined - padded encodings are accepted; trap 3 is never produced
// ---------------------------------------------------------------------------
module leb128_decoder #(
    parameter int MAX_WIDTH = 64,
    parameter int LEN_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_byte,
    input  logic                 signed_mode,
    input  logic                 width_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAX_WIDTH-1:0] out_value,
    output logic [LEN_W-1:0]     out_len,
    output logic [3:0]           trap
);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic [3:0] TRAP_NONE = 4'd0;
    localparam logic [3:0] TRAP_LONG = 4'd1;
    localparam logic [3:0] TRAP_OVF  = 4'd2;
`ifdef LEB128_STRICT_EN
    localparam logic [3:0] TRAP_NONCANON = 4'd3;
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e                 state_q,     state_d;
    logic [63:0]            acc_q,       acc_d;
    logic [LEN_W-1:0]       count_q,     count_d;
    logic                   sgn_q,       sgn_d;
    logic                   w64_q,       w64_d;
    logic                   in_ready_q,  in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [MAX_WIDTH-1:0]   out_value_q, out_value_d;
    logic [LEN_W-1:0]       out_len_q,   out_len_d;
    logic [3:0]             trap_q,      trap_d;
`ifdef LEB128_STRICT_EN
    // bit6 of the previously accepted byte, needed to spot redundant padding
    logic                   prev6_q,     prev6_d;
`endif

    // ------------------------------------------------------------------
    // Per-byte datapath
    // ------------------------------------------------------------------
    logic                   w64_in;
    logic                   first_byte;
    logic                   cur_signed;
    logic                   cur_w64;
    logic [6:0]             shift_amt;
    logic [6:0]             nbits;
    logic [6:0]             target_bits;
    logic [63:0]            acc_next;
    logic [63:0]            fill_mask;
    logic [63:0]            result;
    logic [63:0]            result_ext;
    logic [LEN_W-1:0]       count_inc;
    logic [LEN_W-1:0]       last_idx;
    logic                   is_last;
    logic                   range_ok;
    logic                   accept;

    // A 32-bit-only build has no 64-bit target regardless of width_sel
    assign w64_in      = (MAX_WIDTH == 64) ? width_sel : 1'b0;

    // Mode inputs only matter on the first byte; later bytes use the latch
    assign first_byte  = (count_q == '0);
    assign cur_signed  = first_byte ? signed_mode : sgn_q;
    assign cur_w64     = first_byte ? w64_in      : w64_q;

    assign shift_amt   = 7'(count_q) * 7'd7;
    assign nbits       = shift_amt + 7'd7;
    assign target_bits = cur_w64 ? 7'd64 : 7'd32;

    assign acc_next    = acc_q | ({57'd0, in_byte[6:0]} << shift_amt);
    assign count_inc   = count_q + 1'b1;

    // Byte limit: 5 bytes for a 32-bit target, 10 for 64-bit
    assign last_idx    = cur_w64 ? LEN_W'(9) : LEN_W'(4);
    assign is_last     = (count_q == last_idx);

    // Payload bits of the last allowed byte that lie beyond the target width
    // must be zero (unsigned) or copies of the sign bit (signed)
    always_comb begin
        range_ok = 1'b1;
        case ({cur_signed, cur_w64})
            2'b00:   range_ok = (in_byte[6:4] == 3'b000);
            2'b01:   range_ok = (in_byte[6:1] == 6'd0);
            2'b10:   range_ok = (in_byte[6:4] == {3{in_byte[3]}});
            default: range_ok = (in_byte[6:0] == 7'h00) || (in_byte[6:0] == 7'h7F);
        endcase
    end

    // Sign fill above the last payload bit, only when it lies inside the target
    assign fill_mask  = (cur_signed && in_byte[6] && (nbits < target_bits))
                        ? ({64{1'b1}} << nbits) : 64'd0;
    assign result     = acc_next | fill_mask;

    // 32-bit results are widened from bit 31 (sign) or with zeros (unsigned)
    assign result_ext = cur_w64 ? result
                                : {{32{cur_signed & result[31]}}, result[31:0]};

    assign accept     = in_valid & in_ready_q;

`ifdef LEB128_STRICT_EN
    logic pad_err;
    // A trailing 0x00 / 0x7F only adds information if it changes the sign
    // implied by the previous byte's bit6
    assign pad_err = !first_byte &&
                     (((in_byte == 8'h00) && (!cur_signed || !prev6_q)) ||
                      ((in_byte == 8'h7F) &&   cur_signed &&  prev6_q));
`endif

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sgn_d       = sgn_q;
        w64_d       = w64_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_len_d   = out_len_q;
        trap_d      = trap_q;
`ifdef LEB128_STRICT_EN
        prev6_d     = prev6_q;
`endif

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    acc_d   = acc_next;
                    count_d = count_inc;
`ifdef LEB128_STRICT_EN
                    prev6_d = in_byte[6];
`endif
                    if (first_byte) begin
                        sgn_d = signed_mode;
                        w64_d = w64_in;
                    end

                    if (is_last && in_byte[7]) begin
                        state_d     = ST_ERROR;
                        trap_d      = TRAP_LONG;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b0;
                    end else if (is_last && !range_ok) begin
                        state_d     = ST_ERROR;
                        trap_d      = TRAP_OVF;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b0;
`ifdef LEB128_STRICT_EN
                    end else if (!in_byte[7] && pad_err) begin
                        state_d     = ST_ERROR;
                        trap_d      = TRAP_NONCANON;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b0;
`endif
                    end else if (!in_byte[7]) begin
                        state_d     = ST_DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_value_d = result_ext[MAX_WIDTH-1:0];
                        out_len_d   = count_inc;
                        trap_d      = TRAP_NONE;
                    end
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_ACCUM;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    acc_d       = '0;
                    count_d     = '0;
                end
            end

            ST_ERROR: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end

            default: begin
                state_d     = ST_ACCUM;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort overrides everything above; a byte offered now is dropped
        if (abort) begin
            state_d     = ST_ACCUM;
            acc_d       = '0;
            count_d     = '0;
            trap_d      = TRAP_NONE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State register with asynchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sgn_q       <= 1'b0;
            w64_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_len_q   <= '0;
            trap_q      <= TRAP_NONE;
`ifdef LEB128_STRICT_EN
            prev6_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sgn_q       <= sgn_d;
            w64_q       <= w64_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_len_q   <= out_len_d;
            trap_q      <= trap_d;
`ifdef LEB128_STRICT_EN
            prev6_q     <= prev6_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_len   = out_len_q;
    assign trap      = trap_q;

endmodule
